fp_block_arbiter: RTL and testbench
===================================

FP_BLOCK_ARBITER -- requirements
Module: fp_block_arbiter

Interface
REQ-001 Parameter BLOCK_LEN, default 4: values per block; legal range 2..16.
REQ-002 Clocking: one clock, clk; reset is asynchronous and active-low, port reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous active-low reset.
REQ-005 s0_fp_data_frac / s0_fp_data_expo / s0_fp_data_sign  input  52/11/1  requester 0 fp value.
REQ-006 s0_fp_valid  input  1; s0_fp_ready  output  1  requester 0 handshake.
REQ-007 s1_fp_data_frac / s1_fp_data_expo / s1_fp_data_sign  input  52/11/1  requester 1 fp value.
REQ-008 s1_fp_valid  input  1; s1_fp_ready  output  1  requester 1 handshake.
REQ-009 m_fp_data_frac / m_fp_data_expo / m_fp_data_sign  output  52/11/1  value to the block encoder.
REQ-010 m_fp_valid  output  1; m_fp_ready  input  1  encoder-side handshake.
REQ-011 m_id_data  output  1  index of the requester owning the next block.
REQ-012 m_id_valid  output  1; m_id_ready  input  1  tag handshake.
REQ-013 busy  output  1  high while in state GRANT.

Function
REQ-014 Transfer on any port: valid && ready high at a rising clk edge; valid never depends on ready of the same port.
REQ-015 FSM states: IDLE, GRANT.
REQ-016 IDLE -> GRANT when (s0_fp_valid || s1_fp_valid) && tag slot free (m_id_valid==0, or m_id_valid && m_id_ready that cycle).
REQ-017 Grant selection on IDLE exit: one requester valid -> that one; both valid -> requester != last_served.
REQ-018 On IDLE exit: grant register <= selected index, m_id_data <= selected index, m_id_valid <= 1, count <= 0.
REQ-019 m_id_valid clears on an m_id transfer, unless the same edge loads a new tag (then stays 1 with new data).
REQ-020 In GRANT: m_fp_data_* = granted requester's data, m_fp_valid = granted sN_fp_valid, granted sN_fp_ready = m_fp_ready (combinational, zero latency).
REQ-021 Non-granted requester: ready = 0 at all times; all sN_fp_ready = 0 and m_fp_valid = 0 in IDLE; m_fp_data_* = 0 in IDLE.
REQ-022 count, width clog2(BLOCK_LEN), increments on each m_fp transfer in GRANT.
REQ-023 Transfer with count == BLOCK_LEN-1 -> IDLE, count <= 0, last_served <= grant.
REQ-024 No preemption: the grant holds until exactly BLOCK_LEN transfers; stalls (valid or ready low) of any length keep state and count.
REQ-025 Every block's first beat follows its tag's load: the tag is never emitted after its block's data.
REQ-026 One-cycle IDLE bubble between consecutive blocks; peak throughput BLOCK_LEN beats per BLOCK_LEN+1 cycles.
REQ-027 Tag back-pressure: at most one outstanding tag; IDLE waits while the tag slot is full.
REQ-028 Data fields are passed unmodified; no arithmetic on fp values.

Reset
REQ-029 reset low asynchronously forces: state IDLE, count 0, grant 0, last_served 1 (requester 0 wins the first tie), m_id_valid 0, m_id_data 0.
REQ-030 While reset is low, all outputs: s0_fp_ready 0, s1_fp_ready 0, m_fp_valid 0, m_fp_data_* 0, busy 0.
REQ-031 Reset mid-block discards the partial block; the partial block is not completed after release.
REQ-032 First grant is possible on the first rising edge after reset deasserts.

Verification
REQ-033 Both requesters continuously valid, m_fp_ready=m_id_ready=1, BLOCK_LEN=4 -> tags 0,1,0,1...; output beats s0x4, s1x4, s0x4; one bubble between blocks.
REQ-034 Only s1 valid -> consecutive s1 blocks; tags all 1; s0_fp_ready stays 0.
REQ-035 Grant s0, beat 2 accepted, then s0_fp_valid low 5 cycles while s1 valid -> no s1 beats, count holds at 2, block completes with s0 beats 3,4.
REQ-036 m_id_ready=0 after the first tag -> first block's 4 beats complete, FSM stays IDLE, second tag held until m_id_ready=1, then the next grant occurs.
REQ-037 reset pulsed low after beat 3 of an s1 block -> outputs zero immediately; after release both valid -> tag 0, s0 granted.
REQ-038 m_fp_ready random 50% -> per-block beat count exactly BLOCK_LEN; data order per requester preserved; tags match block sources.

Source files
------------

// File: rtl/fp_block_arbiter.sv
// Two-requester arbiter for fp values. Each grant covers a fixed-length block of beats.
// A source tag is emitted before each block's data, and grants alternate on a tie.
module fp_block_arbiter #(
  parameter int BLOCK_LEN = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [51:0] s0_fp_data_frac,
  input  logic [10:0] s0_fp_data_expo,
  input  logic        s0_fp_data_sign,
  input  logic        s0_fp_valid,
  output logic        s0_fp_ready,
  input  logic [51:0] s1_fp_data_frac,
  input  logic [10:0] s1_fp_data_expo,
  input  logic        s1_fp_data_sign,
  input  logic        s1_fp_valid,
  output logic        s1_fp_ready,
  output logic [51:0] m_fp_data_frac,
  output logic [10:0] m_fp_data_expo,
  output logic        m_fp_data_sign,
  output logic        m_fp_valid,
  input  logic        m_fp_ready,
  output logic        m_id_data,
  output logic        m_id_valid,
  input  logic        m_id_ready,
  output logic        busy
);

  localparam int CW = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic          grant;
  logic          last_served;
  logic [CW-1:0] count;

  logic tag_free;
  logic start;
  logic sel;
  logic beat;
  logic last_beat;

  // A new tag may load on the same edge that the old one is taken.
  assign tag_free  = !m_id_valid || m_id_ready;
  assign start     = (state == IDLE) && (s0_fp_valid || s1_fp_valid) && tag_free;
  assign sel       = (s0_fp_valid && s1_fp_valid) ? !last_served : s1_fp_valid;
  assign beat      = (state == GRANT) && m_fp_valid && m_fp_ready;
  assign last_beat = (count == CW'(BLOCK_LEN - 1));
  assign busy      = (state == GRANT);

  // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    s0_fp_ready    = 1'b0;
    s1_fp_ready    = 1'b0;
    m_fp_valid     = 1'b0;
    m_fp_data_frac = '0;
    m_fp_data_expo = '0;
    m_fp_data_sign = 1'b0;
    if (state == GRANT) begin
      if (grant) begin
        m_fp_data_frac = s1_fp_data_frac;
        m_fp_data_expo = s1_fp_data_expo;
        m_fp_data_sign = s1_fp_data_sign;
        m_fp_valid     = s1_fp_valid;
        s1_fp_ready    = m_fp_ready;
      end else begin
        m_fp_data_frac = s0_fp_data_frac;
        m_fp_data_expo = s0_fp_data_expo;
        m_fp_data_sign = s0_fp_data_sign;
        m_fp_valid     = s0_fp_valid;
        s0_fp_ready    = m_fp_ready;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      count       <= '0;
      grant       <= 1'b0;
      last_served <= 1'b1;
      m_id_valid  <= 1'b0;
      m_id_data   <= 1'b0;
    end else begin
      if (start) begin
        m_id_valid <= 1'b1;
        m_id_data  <= sel;
      end else if (m_id_valid && m_id_ready) begin
        m_id_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state <= GRANT;
            grant <= sel;
            count <= '0;
          end
        end
        GRANT: begin
          if (beat) begin
            if (last_beat) begin
              state       <= IDLE;
              count       <= '0;
              last_served <= grant;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_block_arbiter.sv
// Directed and randomised-ready checks for fp_block_arbiter with BLOCK_LEN = 4.
// Each source presents a running beat index in its fraction field.
module tb_fp_block_arbiter;

  localparam int BL = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        s0_fp_valid = 1'b0, s1_fp_valid = 1'b0;
  logic        m_fp_ready = 1'b0, m_id_ready = 1'b0;
  logic [51:0] s0_fp_data_frac, s1_fp_data_frac, m_fp_data_frac;
  logic [10:0] s0_fp_data_expo, s1_fp_data_expo, m_fp_data_expo;
  logic        s0_fp_data_sign, s1_fp_data_sign, m_fp_data_sign;
  logic        s0_fp_ready, s1_fp_ready, m_fp_valid;
  logic        m_id_data, m_id_valid, busy;

  int idx0, idx1;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Each source advances its beat index on an accepted transfer and restarts on reset.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx0 <= 0;
      idx1 <= 0;
    end else begin
      if (s0_fp_valid && s0_fp_ready) idx0 <= idx0 + 1;
      if (s1_fp_valid && s1_fp_ready) idx1 <= idx1 + 1;
    end
  end

  assign s0_fp_data_frac = 52'h100 + 52'(idx0);
  assign s0_fp_data_expo = 11'h3ff;
  assign s0_fp_data_sign = 1'b0;
  assign s1_fp_data_frac = 52'h200 + 52'(idx1);
  assign s1_fp_data_expo = 11'h400;
  assign s1_fp_data_sign = 1'b1;

  fp_block_arbiter #(.BLOCK_LEN(BL)) dut (
    .clk(clk), .reset(reset),
    .s0_fp_data_frac(s0_fp_data_frac), .s0_fp_data_expo(s0_fp_data_expo),
    .s0_fp_data_sign(s0_fp_data_sign), .s0_fp_valid(s0_fp_valid), .s0_fp_ready(s0_fp_ready),
    .s1_fp_data_frac(s1_fp_data_frac), .s1_fp_data_expo(s1_fp_data_expo),
    .s1_fp_data_sign(s1_fp_data_sign), .s1_fp_valid(s1_fp_valid), .s1_fp_ready(s1_fp_ready),
    .m_fp_data_frac(m_fp_data_frac), .m_fp_data_expo(m_fp_data_expo),
    .m_fp_data_sign(m_fp_data_sign), .m_fp_valid(m_fp_valid), .m_fp_ready(m_fp_ready),
    .m_id_data(m_id_data), .m_id_valid(m_id_valid), .m_id_ready(m_id_ready),
    .busy(busy)
  );

  typedef struct {
    logic        s0v, s1v, mr, ir;
    logic        e_s0r, e_s1r, e_mv, e_busy, e_idv, e_idd;
    logic [63:0] e_data;
  } vec_t;

  function automatic logic [63:0] d0(input int i);
    d0 = {1'b0, 11'h3ff, 52'h100 + 52'(i)};
  endfunction

  function automatic logic [63:0] d1(input int i);
    d1 = {1'b1, 11'h400, 52'h200 + 52'(i)};
  endfunction

  function automatic vec_t v(input logic s0v, s1v, mr, ir, s0r, s1r, mv, bz, idv, idd,
                             input logic [63:0] data);
    vec_t r;
    r.s0v = s0v; r.s1v = s1v; r.mr = mr; r.ir = ir;
    r.e_s0r = s0r; r.e_s1r = s1r; r.e_mv = mv; r.e_busy = bz;
    r.e_idv = idv; r.e_idd = idd; r.e_data = data;
    return r;
  endfunction

  task automatic check(input string nm, input logic [69:0] got, input logic [69:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [69:0] observed();
    observed = {s0_fp_ready, s1_fp_ready, m_fp_valid, busy, m_id_valid, m_id_data,
                m_fp_data_sign, m_fp_data_expo, m_fp_data_frac};
  endfunction

  // Entered just after a rising edge; drives one cycle, checks at the falling edge.
  task automatic apply(input vec_t t, input string nm);
    s0_fp_valid = t.s0v;
    s1_fp_valid = t.s1v;
    m_fp_ready  = t.mr;
    m_id_ready  = t.ir;
    @(negedge clk);
    check(nm, observed(), {t.e_s0r, t.e_s1r, t.e_mv, t.e_busy, t.e_idv, t.e_idd, t.e_data});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string nm);
    reset       = 1'b0;
    s0_fp_valid = 1'b1;
    s1_fp_valid = 1'b1;
    m_fp_ready  = 1'b1;
    m_id_ready  = 1'b1;
    #1;
    check(nm, observed(), 70'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  vec_t tbl [12];

  logic q_tag [$];
  int   bcnt, blocks, exp_src, blk_src, nxt0, nxt1;
  logic src;

  initial begin
    tbl[0]  = v(1,1,1,1, 0,0,0,0,0,0, 64'h0);
    tbl[1]  = v(1,1,1,1, 1,0,1,1,1,0, d0(0));
    tbl[2]  = v(1,1,1,1, 1,0,1,1,0,0, d0(1));
    tbl[3]  = v(1,1,1,1, 1,0,1,1,0,0, d0(2));
    tbl[4]  = v(1,1,1,1, 1,0,1,1,0,0, d0(3));
    tbl[5]  = v(1,1,1,1, 0,0,0,0,0,0, 64'h0);
    tbl[6]  = v(1,1,1,1, 0,1,1,1,1,1, d1(0));
    tbl[7]  = v(1,1,1,1, 0,1,1,1,0,1, d1(1));
    tbl[8]  = v(1,1,1,1, 0,1,1,1,0,1, d1(2));
    tbl[9]  = v(1,1,1,1, 0,1,1,1,0,1, d1(3));
    tbl[10] = v(1,1,1,1, 0,0,0,0,0,1, 64'h0);
    tbl[11] = v(1,1,1,1, 1,0,1,1,1,0, d0(4));

    @(posedge clk);
    #1;
    do_reset("reset_outputs");
    for (int i = 0; i < 12; i++) apply(tbl[i], $sformatf("alternate_c%0d", i));

    // Only s1 requests: back-to-back s1 blocks, s0 never readied.
    do_reset("reset_b");
    apply(v(0,1,1,1, 0,0,0,0,0,0, 64'h0), "s1only_c0");
    apply(v(0,1,1,1, 0,1,1,1,1,1, d1(0)), "s1only_c1");
    for (int i = 1; i < BL; i++)
      apply(v(0,1,1,1, 0,1,1,1,0,1, d1(i)), $sformatf("s1only_c%0d", i + 1));
    apply(v(0,1,1,1, 0,0,0,0,0,1, 64'h0), "s1only_bubble");
    apply(v(0,1,1,1, 0,1,1,1,1,1, d1(4)), "s1only_next");

    // s0 stalls for five cycles mid-block; s1 must not get in.
    do_reset("reset_c");
    apply(v(1,1,1,1, 0,0,0,0,0,0, 64'h0), "stall_c0");
    apply(v(1,1,1,1, 1,0,1,1,1,0, d0(0)), "stall_b1");
    apply(v(1,1,1,1, 1,0,1,1,0,0, d0(1)), "stall_b2");
    for (int i = 0; i < 5; i++)
      apply(v(0,1,1,1, 1,0,0,1,0,0, d0(2)), $sformatf("stall_hold%0d", i));
    apply(v(1,1,1,1, 1,0,1,1,0,0, d0(2)), "stall_b3");
    apply(v(1,1,1,1, 1,0,1,1,0,0, d0(3)), "stall_b4");
    apply(v(1,1,1,1, 0,0,0,0,0,0, 64'h0), "stall_bubble");
    apply(v(1,1,1,1, 0,1,1,1,1,1, d1(0)), "stall_s1_first");

    // Tag slot held full: FSM waits in IDLE until the tag is taken.
    do_reset("reset_d");
    apply(v(1,1,1,0, 0,0,0,0,0,0, 64'h0), "tagbp_c0");
    for (int i = 0; i < BL; i++)
      apply(v(1,1,1,0, 1,0,1,1,1,0, d0(i)), $sformatf("tagbp_b%0d", i + 1));
    apply(v(1,1,1,0, 0,0,0,0,1,0, 64'h0), "tagbp_wait0");
    apply(v(1,1,1,0, 0,0,0,0,1,0, 64'h0), "tagbp_wait1");
    apply(v(1,1,1,1, 0,0,0,0,1,0, 64'h0), "tagbp_release");
    apply(v(1,1,1,0, 0,1,1,1,1,1, d1(0)), "tagbp_grant1");
    apply(v(1,1,1,0, 0,1,1,1,1,1, d1(1)), "tagbp_grant1b");

    // Reset after the third beat of an s1 block; partial block is dropped.
    do_reset("reset_e");
    apply(v(0,1,1,1, 0,0,0,0,0,0, 64'h0), "midrst_c0");
    apply(v(0,1,1,1, 0,1,1,1,1,1, d1(0)), "midrst_b1");
    apply(v(0,1,1,1, 0,1,1,1,0,1, d1(1)), "midrst_b2");
    apply(v(0,1,1,1, 0,1,1,1,0,1, d1(2)), "midrst_b3");
    do_reset("midrst_zero");
    apply(v(1,1,1,1, 0,0,0,0,0,0, 64'h0), "midrst_idle");
    apply(v(1,1,1,1, 1,0,1,1,1,0, d0(0)), "midrst_s0");

    // Random encoder back-pressure: blocks of exactly BL beats, ordered data, matching tags.
    do_reset("reset_f");
    s0_fp_valid = 1'b1;
    s1_fp_valid = 1'b1;
    m_id_ready  = 1'b1;
    bcnt = 0; blocks = 0; exp_src = 0; blk_src = 0; nxt0 = 0; nxt1 = 0;
    for (int c = 0; c < 200; c++) begin
      m_fp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (m_id_valid && m_id_ready) q_tag.push_back(m_id_data);
      if (m_fp_valid && m_fp_ready) begin
        src = m_fp_data_sign;
        if (bcnt == 0) begin
          if (q_tag.size() == 0) check("rnd_tag_present", 70'd0, 70'd1);
          else check("rnd_tag_src", 70'(q_tag.pop_front()), 70'(src));
          check("rnd_block_src", 70'(src), 70'(exp_src));
          blk_src = int'(src);
        end else begin
          check("rnd_same_src", 70'(src), 70'(blk_src));
        end
        if (src) begin
          check("rnd_s1_order", 70'({m_fp_data_sign, m_fp_data_expo, m_fp_data_frac}), 70'(d1(nxt1)));
          nxt1++;
        end else begin
          check("rnd_s0_order", 70'({m_fp_data_sign, m_fp_data_expo, m_fp_data_frac}), 70'(d0(nxt0)));
          nxt0++;
        end
        bcnt++;
        if (bcnt == BL) begin
          bcnt = 0;
          blocks++;
          exp_src = 1 - exp_src;
        end
      end
      @(posedge clk);
      #1;
    end
    check("rnd_progress", 70'(blocks > 5), 70'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
